// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache slice.
// Holds the access-sequencer state encoding and the default address and
// counter widths used by the datapath, the sequencer and the top level.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        FILL   = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/cache_access_sequencer_if.sv
// Bundle between the access sequencer and its datapath/memory environment.
//   start    : run request (level)
//   hit      : datapath tag match for the presented address
//   mem_ack  : one-cycle "line ready" pulse from backing memory
//   address  : word address presented to datapath/memory
//   mem_req  : line-fetch request
//   wr_en    : datapath line-fill strobe
//   busy     : sweep in progress
//   done     : sweep complete
//   hit_num  : saturating hit total for the current run
//   miss_num : saturating miss total for the current run
// master = sequencer side, slave = datapath/memory/control side.
interface cache_access_sequencer_if import cache_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) ();

    logic              start;
    logic              hit;
    logic              mem_ack;
    logic [ADDR_W-1:0] address;
    logic              mem_req;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  hit_num;
    logic [CNT_W-1:0]  miss_num;

    modport master (
        input  start, hit, mem_ack,
        output address, mem_req, wr_en, busy, done, hit_num, miss_num
    );

    modport slave (
        output start, hit, mem_ack,
        input  address, mem_req, wr_en, busy, done, hit_num, miss_num
    );

endinterface

// File: rtl/cache_access_sequencer_sat_counter.sv
// Saturating up-counter used for the hit and miss totals.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   clr   : synchronous clear (start of a new run)
//   inc   : increment by one; holds at all-ones instead of wrapping
//   count : current total
module sat_counter import cache_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_access_sequencer.sv
// Control/sequencing FSM for the direct-mapped data cache datapath.
// On start it sweeps NUM_ACCESSES consecutive word addresses from
// BASE_ADDR, samples the datapath hit flag for each, fetches missing lines
// over a req/ack handshake followed by a one-cycle fill strobe, and keeps
// saturating hit/miss totals. All outputs are registers or state decodes.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, abandons any run in flight
//   bus : sequencer side of cache_access_sequencer_if (see interface file)
module cache_access_sequencer import cache_pkg::*; #(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned NUM_ACCESSES = 8192
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_access_sequencer_if.master bus
);

    // A one-access run still needs a 1-bit index register.
    localparam int unsigned        IDX_W    = (NUM_ACCESSES > 1) ? $clog2(NUM_ACCESSES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ACCESSES - 1);
    localparam logic [ADDR_W-1:0]  BASE     = ADDR_W'(BASE_ADDR);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic              load_run;
    logic              advance;
    logic              hit_inc;
    logic              miss_inc;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= BASE;
            idx_q  <= '0;
        end else begin
            state <= nxt;
            if (load_run) begin
                addr_q <= BASE;
                idx_q  <= '0;
            end else if (advance) begin
                // Address wraps modulo 2^ADDR_W by truncation.
                addr_q <= addr_q + 1'b1;
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        nxt      = state;
        load_run = 1'b0;
        advance  = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_run = 1'b1;
                    nxt      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.hit) begin
                    hit_inc = 1'b1;
                    nxt     = NEXT;
                end else begin
                    nxt = MISS;
                end
            end
            MISS: begin
                if (bus.mem_ack) begin
                    nxt = FILL;
                end
            end
            FILL: begin
                miss_inc = 1'b1;
                nxt      = NEXT;
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    nxt = DONE;
                end else begin
                    advance = 1'b1;
                    nxt     = LOOKUP;
                end
            end
            DONE: begin
                // Requires start to drop before a new run can begin.
                if (!bus.start) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_run),
        .inc   (hit_inc),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_run),
        .inc   (miss_inc),
        .count (miss_cnt)
    );

    assign bus.address  = addr_q;
    assign bus.mem_req  = (state == MISS);
    assign bus.wr_en    = (state == FILL);
    assign bus.busy     = (state != IDLE) && (state != DONE);
    assign bus.done     = (state == DONE);
    assign bus.hit_num  = hit_cnt;
    assign bus.miss_num = miss_cnt;

endmodule

// File: tb/tb_cache_access_sequencer.sv
// Directed, scoreboard-based bench for cache_access_sequencer.
// Four DUT configurations share clk/rst; one is selected at a time and its
// outputs are muxed onto common observation signals. Expected sweep
// addresses and fill addresses are queued when a run is launched and popped
// as the selected DUT presents them.
module tb_cache_access_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_r   = 1'b0;
    logic stray_ack = 1'b0;
    logic ack_r     = 1'b0;
    int   sel       = 0;
    int   mode      = 0;
    int   ack_delay = 0;
    int   req_n     = 0;
    int   req_cycles = 0;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_addr_q[$];
    logic [14:0] exp_fill_q[$];

    logic [14:0] o_addr;
    logic        o_req, o_wr, o_busy, o_done;
    logic [15:0] o_hitn, o_missn;
    logic        hit_in, ack_in;

    logic        ack_at_edge = 1'b0;
    logic        wr_prev     = 1'b0;
    logic        busy_prev   = 1'b0;
    logic [14:0] addr_prev   = '0;

    cache_access_sequencer_if #(.ADDR_W(15), .CNT_W(16)) ifa ();
    cache_access_sequencer_if #(.ADDR_W(15), .CNT_W(16)) ifb ();
    cache_access_sequencer_if #(.ADDR_W(15), .CNT_W(16)) ifc ();
    cache_access_sequencer_if #(.ADDR_W(15), .CNT_W(2))  ifd ();

    cache_access_sequencer #(.ADDR_W(15), .CNT_W(16), .BASE_ADDR(1024), .NUM_ACCESSES(4))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    cache_access_sequencer #(.ADDR_W(15), .CNT_W(16), .BASE_ADDR(1024), .NUM_ACCESSES(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.master));
    cache_access_sequencer #(.ADDR_W(15), .CNT_W(16), .BASE_ADDR(32766), .NUM_ACCESSES(3))
        dut_c (.clk(clk), .rst(rst), .bus(ifc.master));
    cache_access_sequencer #(.ADDR_W(15), .CNT_W(2), .BASE_ADDR(1024), .NUM_ACCESSES(6))
        dut_d (.clk(clk), .rst(rst), .bus(ifd.master));

    assign ack_in = ack_r | stray_ack;
    assign hit_in = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ~o_addr[0];

    assign ifa.start = (sel == 0) && start_r;
    assign ifb.start = (sel == 1) && start_r;
    assign ifc.start = (sel == 2) && start_r;
    assign ifd.start = (sel == 3) && start_r;
    assign ifa.hit = hit_in;
    assign ifb.hit = hit_in;
    assign ifc.hit = hit_in;
    assign ifd.hit = hit_in;
    assign ifa.mem_ack = (sel == 0) && ack_in;
    assign ifb.mem_ack = (sel == 1) && ack_in;
    assign ifc.mem_ack = (sel == 2) && ack_in;
    assign ifd.mem_ack = (sel == 3) && ack_in;

    always_comb begin
        case (sel)
            1: begin
                o_addr = ifb.address; o_req = ifb.mem_req; o_wr = ifb.wr_en;
                o_busy = ifb.busy; o_done = ifb.done; o_hitn = ifb.hit_num; o_missn = ifb.miss_num;
            end
            2: begin
                o_addr = ifc.address; o_req = ifc.mem_req; o_wr = ifc.wr_en;
                o_busy = ifc.busy; o_done = ifc.done; o_hitn = ifc.hit_num; o_missn = ifc.miss_num;
            end
            3: begin
                o_addr = ifd.address; o_req = ifd.mem_req; o_wr = ifd.wr_en;
                o_busy = ifd.busy; o_done = ifd.done;
                o_hitn = {14'd0, ifd.hit_num}; o_missn = {14'd0, ifd.miss_num};
            end
            default: begin
                o_addr = ifa.address; o_req = ifa.mem_req; o_wr = ifa.wr_en;
                o_busy = ifa.busy; o_done = ifa.done; o_hitn = ifa.hit_num; o_missn = ifa.miss_num;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic hit_of(input logic [14:0] a, input int m);
        return (m == 0) ? 1'b1 : (m == 1) ? 1'b0 : ~a[0];
    endfunction

    function automatic int sat(input int v, input int cmax);
        return (v > cmax) ? cmax : v;
    endfunction

    // Memory model: acks in the (ack_delay+1)-th cycle mem_req is seen high.
    always @(negedge clk) begin
        if (o_req) begin
            req_n = req_n + 1;
            ack_r = (req_n == ack_delay + 1);
        end else begin
            req_n = 0;
            ack_r = 1'b0;
        end
    end

    always @(posedge clk) ack_at_edge <= ack_in;

    // Scoreboard side: pop expected addresses as the DUT presents them.
    always @(negedge clk) begin
        if (o_req) req_cycles = req_cycles + 1;
        if (o_busy && (!busy_prev || (o_addr != addr_prev))) begin
            chk("addr_pending", 32'(exp_addr_q.size() > 0), 1);
            if (exp_addr_q.size() > 0) chk("addr_seq", 32'(o_addr), 32'(exp_addr_q.pop_front()));
        end
        if (o_wr) begin
            chk("wr_after_ack", 32'(ack_at_edge), 1);
            chk("wr_single", 32'(wr_prev), 0);
            chk("fill_pending", 32'(exp_fill_q.size() > 0), 1);
            if (exp_fill_q.size() > 0) chk("fill_addr", 32'(o_addr), 32'(exp_fill_q.pop_front()));
        end
        busy_prev = o_busy;
        addr_prev = o_addr;
        wr_prev   = o_wr;
    end

    task automatic run(input int s, input logic [14:0] base, input int n, input int m,
                       input int dly, input bit hold, input int cmax);
        int exp_hits = 0;
        int exp_miss = 0;
        int exp_cyc  = 0;
        int cyc      = 0;
        int req0;
        bit seen     = 1'b0;
        bit ok       = 1'b0;
        logic [14:0] a;
        sel = s; mode = m; ack_delay = dly;
        exp_addr_q.delete();
        exp_fill_q.delete();
        for (int i = 0; i < n; i++) begin
            a = base + 15'(i);
            exp_addr_q.push_back(a);
            if (hit_of(a, m)) begin
                exp_hits++; exp_cyc += 2;
            end else begin
                exp_miss++; exp_cyc += 4 + dly; exp_fill_q.push_back(a);
            end
        end
        req0 = req_cycles;
        start_r = 1'b1;
        for (int t = 0; t < 4000 && !ok; t++) begin
            @(negedge clk);
            if (o_busy) begin
                cyc++;
                if (!seen) begin
                    seen = 1'b1;
                    chk("clr_hit", 32'(o_hitn), 0);
                    chk("clr_miss", 32'(o_missn), 0);
                    if (!hold) start_r = 1'b0;
                end
            end
            if (o_done) ok = 1'b1;
        end
        chk("done_reached", 32'(ok), 1);
        chk("hit_num", 32'(o_hitn), 32'(sat(exp_hits, cmax)));
        chk("miss_num", 32'(o_missn), 32'(sat(exp_miss, cmax)));
        chk("busy_cycles", 32'(cyc), 32'(exp_cyc));
        chk("req_cycles", 32'(req_cycles - req0), 32'(exp_miss * (dly + 1)));
        chk("fill_left", 32'(exp_fill_q.size()), 0);
        chk("addr_left", 32'(exp_addr_q.size()), 0);
        if (hold) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_hold", 32'(o_done), 1);
                chk("busy_in_done", 32'(o_busy), 0);
            end
            start_r = 1'b0;
        end
        @(negedge clk);
        chk("idle_done", 32'(o_done), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_hit_hold", 32'(o_hitn), 32'(sat(exp_hits, cmax)));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        #1;
        chk("rst_addr_a", 32'(o_addr), 1024);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_req", 32'(o_req), 0);
        chk("rst_wr", 32'(o_wr), 0);
        chk("rst_hit", 32'(o_hitn), 0);
        chk("rst_miss", 32'(o_missn), 0);
        sel = 2;
        #1;
        chk("rst_addr_c", 32'(o_addr), 32766);
        @(negedge clk);

        // All hits, 4 accesses
        run(0, 15'd1024, 4, 0, 0, 1'b0, 65535);
        // All misses, ack three cycles into the request
        run(0, 15'd1024, 4, 1, 3, 1'b0, 65535);

        // Reset during a miss; a later ack in IDLE is ignored
        sel = 0; mode = 2; ack_delay = 1000;
        exp_addr_q.delete();
        exp_fill_q.delete();
        exp_addr_q.push_back(15'd1024);
        exp_addr_q.push_back(15'd1025);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        for (int t = 0; t < 50 && !o_req; t++) @(negedge clk);
        chk("miss_reached", 32'(o_req), 1);
        chk("hit_before_rst", 32'(o_hitn), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_req", 32'(o_req), 0);
        chk("rst_mid_busy", 32'(o_busy), 0);
        chk("rst_mid_hit", 32'(o_hitn), 0);
        chk("rst_mid_miss", 32'(o_missn), 0);
        chk("rst_mid_addr", 32'(o_addr), 1024);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        chk("stray_busy", 32'(o_busy), 0);
        chk("stray_req", 32'(o_req), 0);
        @(negedge clk);
        chk("stray_wr", 32'(o_wr), 0);
        chk("stray_addr_left", 32'(exp_addr_q.size()), 0);

        // Alternating hit/miss, start held high through the run
        run(1, 15'd1024, 8, 2, 2, 1'b1, 65535);
        // Address wrap at the top of the address space
        run(2, 15'd32766, 3, 2, 1, 1'b0, 65535);
        // Narrow counters saturate; start held in DONE; rerun clears
        run(3, 15'd1024, 6, 0, 0, 1'b1, 3);
        run(3, 15'd1024, 6, 0, 0, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
